// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller.
// LOAD streams loader words into a single-port synchronous-read memory.
// RUN serves CPU fetches with a fixed one-cycle response latency.
module inst_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  // loader stream
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        reload,
  // cpu fetch port
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  output logic        cpu_valid,
  output logic [31:0] cpu_inst,
  output logic        cpu_stall,
  // memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  // status
  output logic        load_done,
  output logic [31:0] load_words,
  output logic        err_misaligned,
  output logic        err_overflow
);

  localparam logic [31:0] LastIdx   = 32'(DEPTH_WORDS - 1);
  localparam logic [31:0] DepthWrds = 32'(DEPTH_WORDS);

  typedef enum logic [0:0] {StLoad, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] load_words_q, load_words_d;
  logic        load_done_q, load_done_d;
  logic        err_mis_q, err_mis_d;
  logic        err_ovf_q, err_ovf_d;
  logic        resp_pend_q, resp_pend_d;
  logic        resp_nop_q, resp_nop_d;
  logic [31:0] inst_hold_q, inst_hold_d;

  logic        in_load;
  logic        xfer;
  logic        fetch;
  logic        fetch_rd;
  logic        addr_aligned;
  logic        addr_in_range;
  logic [31:0] resp_inst;

  // Request decode; rst gates everything so reset forces a quiet memory port.
  always_comb begin
    in_load       = (state_q == StLoad);
    addr_aligned  = (cpu_addr[1:0] == 2'b00);
    addr_in_range = ({2'b00, cpu_addr[31:2]} < DepthWrds);
    // reload wins over a same-cycle loader word
    xfer          = in_load && ld_valid && !reload && !rst;
    fetch         = !in_load && cpu_req && !rst;
    fetch_rd      = fetch && addr_aligned && addr_in_range;
  end

  // Output drive: memory port, loader handshake, fetch response.
  always_comb begin
    ld_ready  = in_load && !rst;
    cpu_stall = in_load;
    mem_en    = xfer || fetch_rd;
    mem_we    = xfer;
    mem_wdata = xfer ? ld_data : 32'h0;
    if (xfer) begin
      mem_addr = {load_words_q[29:0], 2'b00};
    end else if (fetch_rd) begin
      mem_addr = cpu_addr;
    end else begin
      mem_addr = 32'h0;
    end
    resp_inst      = resp_nop_q ? NOP_INST : mem_rdata;
    cpu_valid      = resp_pend_q;
    // Without a response the port keeps showing the last delivered word.
    cpu_inst       = resp_pend_q ? resp_inst : inst_hold_q;
    load_done      = load_done_q;
    load_words     = load_words_q;
    err_misaligned = err_mis_q;
    err_overflow   = err_ovf_q;
  end

  // Next-state: FSM, load counter, sticky flags and the response pipeline.
  always_comb begin
    state_d      = state_q;
    load_words_d = load_words_q;
    load_done_d  = load_done_q;
    err_mis_d    = err_mis_q;
    err_ovf_d    = err_ovf_q;
    inst_hold_d  = resp_pend_q ? resp_inst : inst_hold_q;
    // A fetch accepted this cycle always answers next cycle, even across reload.
    resp_pend_d  = fetch;
    resp_nop_d   = !fetch_rd;

    if (fetch && !addr_aligned) begin
      err_mis_d = 1'b1;
    end

    if (reload) begin
      state_d      = StLoad;
      load_words_d = 32'h0;
      load_done_d  = 1'b0;
      err_ovf_d    = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (xfer) begin
            load_words_d = load_words_q + 32'd1;
            if (ld_last) begin
              state_d     = StRun;
              load_done_d = 1'b1;
            end else if (load_words_q == LastIdx) begin
              // Final memory word written without ld_last: stop loading.
              state_d     = StRun;
              load_done_d = 1'b1;
              err_ovf_d   = 1'b1;
            end
          end
        end
        StRun: begin
          state_d = StRun;
        end
        default: state_d = StLoad;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLoad;
      load_words_q <= 32'h0;
      load_done_q  <= 1'b0;
      err_mis_q    <= 1'b0;
      err_ovf_q    <= 1'b0;
      resp_pend_q  <= 1'b0;
      resp_nop_q   <= 1'b0;
      inst_hold_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      load_words_q <= load_words_d;
      load_done_q  <= load_done_d;
      err_mis_q    <= err_mis_d;
      err_ovf_q    <= err_ovf_d;
      resp_pend_q  <= resp_pend_d;
      resp_nop_q   <= resp_nop_d;
      inst_hold_q  <= inst_hold_d;
    end
  end

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl against a cycle-level reference model.
module tb_inst_mem_ctrl;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        reload;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_valid;
  logic [31:0] cpu_inst;
  logic        cpu_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        load_done;
  logic [31:0] load_words;
  logic        err_misaligned;
  logic        err_overflow;

  inst_mem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .NOP_INST   (NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_valid      (ld_valid),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .ld_ready      (ld_ready),
    .reload        (reload),
    .cpu_req       (cpu_req),
    .cpu_addr      (cpu_addr),
    .cpu_valid     (cpu_valid),
    .cpu_inst      (cpu_inst),
    .cpu_stall     (cpu_stall),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .load_done     (load_done),
    .load_words    (load_words),
    .err_misaligned(err_misaligned),
    .err_overflow  (err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read single-port memory driven only by the DUT.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  int n_cmp;
  int n_bad;

  // Reference model: what the program image and status should be.
  int unsigned m_words;
  bit          m_run, m_done, m_ovf, m_mis, m_pend;
  logic [31:0] m_pend_val, m_hold;
  logic [31:0] ref_mem [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_words = 0; m_run = 0; m_done = 0; m_ovf = 0; m_mis = 0;
    m_pend = 0; m_pend_val = 32'h0; m_hold = 32'h0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ld_ready"}, ld_ready, 0);
    chk({tag, ".cpu_stall"}, cpu_stall, 1);
    chk({tag, ".cpu_valid"}, cpu_valid, 0);
    chk({tag, ".cpu_inst"}, cpu_inst, 0);
    chk({tag, ".mem_en"}, mem_en, 0);
    chk({tag, ".mem_we"}, mem_we, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".load_done"}, load_done, 0);
    chk({tag, ".load_words"}, load_words, 0);
    chk({tag, ".err_mis"}, err_misaligned, 0);
    chk({tag, ".err_ovf"}, err_overflow, 0);
  endtask

  // One clock cycle with the currently driven inputs: check, then advance model.
  task automatic step();
    bit xfer, fetch_any, fetch_rd;
    xfer      = !m_run && ld_valid && !reload;
    fetch_any = m_run && cpu_req;
    fetch_rd  = fetch_any && (cpu_addr[1:0] == 2'b00) && ((cpu_addr >> 2) < DEPTH);
    @(negedge clk);
    chk("ld_ready", ld_ready, !m_run);
    chk("cpu_stall", cpu_stall, !m_run);
    chk("mem_en", mem_en, xfer || fetch_rd);
    chk("mem_we", mem_we, xfer);
    if (xfer) begin
      chk("wr_addr", mem_addr, m_words * 4);
      chk("wr_data", mem_wdata, ld_data);
    end
    if (fetch_rd) chk("rd_addr", mem_addr, cpu_addr);
    chk("cpu_valid", cpu_valid, m_pend);
    chk("cpu_inst", cpu_inst, m_pend ? m_pend_val : m_hold);
    chk("load_words", load_words, m_words);
    chk("load_done", load_done, m_done);
    chk("err_ovf", err_overflow, m_ovf);
    chk("err_mis", err_misaligned, m_mis);
    @(posedge clk);
    if (m_pend) m_hold = m_pend_val;
    m_pend     = fetch_any;
    m_pend_val = fetch_rd ? ref_mem[cpu_addr >> 2] : NOP;
    if (fetch_any && cpu_addr[1:0] != 2'b00) m_mis = 1;
    if (reload) begin
      m_words = 0; m_done = 0; m_ovf = 0; m_run = 0;
    end else if (xfer) begin
      ref_mem[m_words] = ld_data;
      if (ld_last) begin
        m_run = 1; m_done = 1;
      end else if (m_words == DEPTH - 1) begin
        m_run = 1; m_done = 1; m_ovf = 1;
      end
      m_words++;
    end
    #1;
  endtask

  task automatic ld(input logic [31:0] data, input bit last);
    ld_valid = 1; ld_data = data; ld_last = last;
    step();
    ld_valid = 0; ld_last = 0;
  endtask

  task automatic fe(input logic [31:0] addr);
    cpu_req = 1; cpu_addr = addr;
    step();
    cpu_req = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned n;
    n = (m_words == 0) ? 1 : m_words;
    if (n > DEPTH) n = DEPTH;
    case ($urandom_range(0, 5))
      0:       return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      1:       return ($urandom() | 32'h400) & 32'hFFFF_FFFC;
      default: return 32'($urandom_range(0, n - 1)) << 2;
    endcase
  endfunction

  initial begin
    n_cmp = 0; n_bad = 0;
    model_reset();
    rst = 1; ld_valid = 0; ld_data = 0; ld_last = 0; reload = 0;
    cpu_req = 0; cpu_addr = 0;

    // Reset holds outputs quiet even with live inputs.
    repeat (2) @(posedge clk);
    #1;
    ld_valid = 1; ld_data = $urandom(); cpu_req = 1; cpu_addr = 4;
    #1 chk_reset("rst");
    @(posedge clk);
    #1;
    ld_valid = 0; cpu_req = 0; rst = 0;

    // Fetch in LOAD is ignored.
    cpu_req = 1; cpu_addr = 0; step(); cpu_req = 0;
    step();

    // Reference program.
    ld(32'h00500093, 0);
    ld(32'h00100113, 0);
    ld(32'h002081B3, 0);
    ld(32'h00000063, 1);
    step();
    chk("prog.words", load_words, 4);
    chk("prog.done", load_done, 1);

    fe(4);
    chk("fetch4", cpu_inst, 32'h00100113);
    step();
    fe(0); fe(4); fe(8);
    step();
    fe(6);
    chk("mis.inst", cpu_inst, NOP);
    chk("mis.flag", err_misaligned, 1);
    step();
    fe(32'h400);
    chk("oor.inst", cpu_inst, NOP);
    step();

    // Random fetch traffic with loader noise.
    repeat (40) begin
      cpu_req  = ($urandom_range(0, 3) != 0);
      cpu_addr = rand_addr();
      ld_valid = $urandom_range(0, 1) != 0;
      ld_data  = $urandom();
      step();
    end
    cpu_req = 0; ld_valid = 0;
    step();

    // reload in RUN with a same-cycle fetch.
    reload = 1; cpu_req = 1; cpu_addr = 8;
    step();
    reload = 0; cpu_req = 0;
    chk("rl.valid", cpu_valid, 1);
    chk("rl.inst", cpu_inst, 32'h002081B3);
    chk("rl.stall", cpu_stall, 1);
    chk("rl.words", load_words, 0);
    step();

    // reload in LOAD beats a same-cycle transfer, then restarts the count.
    ld_valid = 1; ld_data = $urandom(); reload = 1;
    step();
    reload = 0; ld_valid = 0;
    repeat (3) ld($urandom(), 0);
    reload = 1; step(); reload = 0;
    step();

    // Fill the whole memory without ld_last.
    for (int c = 0; c < 4000 && !m_run; c++) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_data  = $urandom();
      cpu_req  = $urandom_range(0, 1) != 0;
      cpu_addr = $urandom() & 32'h3FC;
      step();
    end
    ld_valid = 0; cpu_req = 0;
    chk("ovf.flag", err_overflow, 1);
    chk("ovf.words", load_words, DEPTH);
    chk("ovf.done", load_done, 1);
    ld_valid = 1; ld_data = $urandom();
    step();
    ld_valid = 0;

    repeat (60) begin
      cpu_req  = ($urandom_range(0, 3) != 0);
      cpu_addr = rand_addr();
      step();
    end
    cpu_req = 0;

    // Reset mid-fetch drops the pending response.
    fe(32'($urandom_range(0, DEPTH - 1)) << 2);
    rst = 1;
    #1 chk_reset("rst_fetch");
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    step();

    // Reset mid-load.
    ld($urandom(), 0);
    ld($urandom(), 0);
    ld_valid = 1; ld_data = $urandom(); rst = 1;
    #1 chk_reset("rst_load");
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    ld_valid = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
